// File: rtl/video_timing_controller.sv
`default_nettype none
// ============================================================================
// Module   : video_timing_controller
// Purpose  : Runtime-reconfigurable raster timing generator. Produces
//            hsync/vsync/de, active-area pixel coordinates and frame/line
//            strobes. Timing fields are staged in a shadow set through a
//            valid/ready config port and copied into the active set only at
//            the last pixel of a frame, so a mode change never tears a frame.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock        in   pixel clock
//   reset        in   synchronous, active-high
//   cfg_valid    in   config write request
//   cfg_ready    out  request accepted when valid & ready (low while pending)
//   cfg_addr     in   0..3 H fields, 4..7 V fields, 8 COMMIT, 9..15 ignored
//   cfg_data     in   field value (low H_BITS / V_BITS used)
//   cfg_pending  out  commit accepted, waiting for frame end
//   cfg_applied  out  1-cycle pulse: shadow copied into active set
//   cfg_error    out  1-cycle pulse: commit rejected (total too large)
//   video_de     out  active pixel
//   video_hsync  out  horizontal sync region
//   video_vsync  out  vertical sync region
//   pixel_x      out  active-area column, 0 outside active area
//   pixel_y      out  active-area row, 0 outside active area
//   frame_start  out  pulse at h=0, v=0
//   line_start   out  pulse at every h=0
// ============================================================================
module video_timing_controller #(
  parameter int H_BITS      = 12,
  parameter int V_BITS      = 11,
  parameter int DEF_HSYNC   = 40,
  parameter int DEF_HBACK   = 220,
  parameter int DEF_HACTIVE = 1280,
  parameter int DEF_HFRONT  = 110,
  parameter int DEF_VSYNC   = 5,
  parameter int DEF_VBACK   = 20,
  parameter int DEF_VACTIVE = 720,
  parameter int DEF_VFRONT  = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [3:0]        cfg_addr,
  input  logic [15:0]       cfg_data,
  output logic              cfg_pending,
  output logic              cfg_applied,
  output logic              cfg_error,
  output logic              video_de,
  output logic              video_hsync,
  output logic              video_vsync,
  output logic [H_BITS-1:0] pixel_x,
  output logic [V_BITS-1:0] pixel_y,
  output logic              frame_start,
  output logic              line_start
);

  // Totals are formed two bits wider than the fields so that the sum of four
  // fields can never wrap and the "exceeds counter range" test is exact.
  localparam int c_HW = H_BITS + 2;
  localparam int c_VW = V_BITS + 2;

  localparam logic [c_HW-1:0] c_H_LIMIT = {2'b01, {H_BITS{1'b0}}};
  localparam logic [c_VW-1:0] c_V_LIMIT = {2'b01, {V_BITS{1'b0}}};

  // Field order inside each set: 0 sync, 1 back porch, 2 active, 3 front porch
  localparam logic [H_BITS-1:0] c_DEF_H [4] = '{
    H_BITS'(DEF_HSYNC), H_BITS'(DEF_HBACK), H_BITS'(DEF_HACTIVE), H_BITS'(DEF_HFRONT)
  };
  localparam logic [V_BITS-1:0] c_DEF_V [4] = '{
    V_BITS'(DEF_VSYNC), V_BITS'(DEF_VBACK), V_BITS'(DEF_VACTIVE), V_BITS'(DEF_VFRONT)
  };

  logic [H_BITS-1:0] r_act_h [4];
  logic [V_BITS-1:0] r_act_v [4];
  logic [H_BITS-1:0] r_sh_h  [4];
  logic [V_BITS-1:0] r_sh_v  [4];

  logic [H_BITS-1:0] r_hcnt;
  logic [V_BITS-1:0] r_vcnt;
  logic              r_pending;
  logic              r_applied;
  logic              r_error;
  logic              r_de;
  logic              r_hsync;
  logic              r_vsync;
  logic [H_BITS-1:0] r_px;
  logic [V_BITS-1:0] r_py;
  logic              r_frame_start;
  logic              r_line_start;

  // --------------------------------------------------------------------------
  // Active-set geometry
  // --------------------------------------------------------------------------
  logic [c_HW-1:0] w_h_total, w_h_de_start, w_h_de_end, w_hcnt_ext, w_h_off;
  logic [c_VW-1:0] w_v_total, w_v_de_start, w_v_de_end, w_vcnt_ext, w_v_off;
  logic            w_h_last, w_v_last, w_frame_end;
  logic            w_h_in_de, w_v_in_de, w_de;

  assign w_hcnt_ext   = {2'b00, r_hcnt};
  assign w_vcnt_ext   = {2'b00, r_vcnt};
  assign w_h_de_start = {2'b00, r_act_h[0]} + {2'b00, r_act_h[1]};
  assign w_h_de_end   = w_h_de_start + {2'b00, r_act_h[2]};
  assign w_h_total    = w_h_de_end + {2'b00, r_act_h[3]};
  assign w_v_de_start = {2'b00, r_act_v[0]} + {2'b00, r_act_v[1]};
  assign w_v_de_end   = w_v_de_start + {2'b00, r_act_v[2]};
  assign w_v_total    = w_v_de_end + {2'b00, r_act_v[3]};

  assign w_h_last    = (w_hcnt_ext == w_h_total - 1'b1);
  assign w_v_last    = (w_vcnt_ext == w_v_total - 1'b1);
  assign w_frame_end = w_h_last & w_v_last;

  assign w_h_in_de = (w_hcnt_ext >= w_h_de_start) && (w_hcnt_ext < w_h_de_end);
  assign w_v_in_de = (w_vcnt_ext >= w_v_de_start) && (w_vcnt_ext < w_v_de_end);
  assign w_de      = w_h_in_de & w_v_in_de;
  assign w_h_off   = w_hcnt_ext - w_h_de_start;
  assign w_v_off   = w_vcnt_ext - w_v_de_start;

  // --------------------------------------------------------------------------
  // Config port decode
  // --------------------------------------------------------------------------
  logic              w_fire;
  logic [H_BITS-1:0] w_h_wval;
  logic [V_BITS-1:0] w_v_wval;
  logic [c_HW-1:0]   w_sh_h_total;
  logic [c_VW-1:0]   w_sh_v_total;
  logic              w_commit_bad;

  assign cfg_ready = ~r_pending;
  assign w_fire    = cfg_valid & ~r_pending;

  // A zero field is stored as 1 so every region lasts at least one cycle.
  assign w_h_wval = (cfg_data[H_BITS-1:0] == '0) ? H_BITS'(1) : cfg_data[H_BITS-1:0];
  assign w_v_wval = (cfg_data[V_BITS-1:0] == '0) ? V_BITS'(1) : cfg_data[V_BITS-1:0];

  assign w_sh_h_total = {2'b00, r_sh_h[0]} + {2'b00, r_sh_h[1]}
                      + {2'b00, r_sh_h[2]} + {2'b00, r_sh_h[3]};
  assign w_sh_v_total = {2'b00, r_sh_v[0]} + {2'b00, r_sh_v[1]}
                      + {2'b00, r_sh_v[2]} + {2'b00, r_sh_v[3]};
  assign w_commit_bad = (w_sh_h_total > c_H_LIMIT) || (w_sh_v_total > c_V_LIMIT);

  // --------------------------------------------------------------------------
  // Raster counters, shadow/active sets and commit handling
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_hcnt    <= '0;
      r_vcnt    <= '0;
      r_act_h   <= c_DEF_H;
      r_act_v   <= c_DEF_V;
      r_sh_h    <= c_DEF_H;
      r_sh_v    <= c_DEF_V;
      r_pending <= 1'b0;
      r_applied <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_applied <= 1'b0;
      r_error   <= 1'b0;

      if (w_h_last) begin
        r_hcnt <= '0;
        r_vcnt <= w_v_last ? '0 : r_vcnt + 1'b1;
      end else begin
        r_hcnt <= r_hcnt + 1'b1;
      end

      // Counters wrap to 0 on this same edge, so the new set starts cleanly
      // at the top-left pixel. Shadow is left intact for re-commits.
      if (r_pending && w_frame_end) begin
        r_act_h   <= r_sh_h;
        r_act_v   <= r_sh_v;
        r_pending <= 1'b0;
        r_applied <= 1'b1;
      end

      // Fire implies !pending, so this never collides with the apply above.
      if (w_fire) begin
        if (cfg_addr[3] == 1'b0) begin
          if (cfg_addr[2] == 1'b0) begin
            r_sh_h[cfg_addr[1:0]] <= w_h_wval;
          end else begin
            r_sh_v[cfg_addr[1:0]] <= w_v_wval;
          end
        end else if (cfg_addr == 4'd8) begin
          if (w_commit_bad) begin
            r_error <= 1'b1;
          end else begin
            r_pending <= 1'b1;
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registered video outputs (one cycle behind the counters)
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_de          <= 1'b0;
      r_hsync       <= 1'b0;
      r_vsync       <= 1'b0;
      r_px          <= '0;
      r_py          <= '0;
      r_frame_start <= 1'b0;
      r_line_start  <= 1'b0;
    end else begin
      r_de          <= w_de;
      r_hsync       <= (r_hcnt < r_act_h[0]);
      r_vsync       <= (r_vcnt < r_act_v[0]);
      r_px          <= w_de ? w_h_off[H_BITS-1:0] : '0;
      r_py          <= w_de ? w_v_off[V_BITS-1:0] : '0;
      r_frame_start <= (r_hcnt == '0) && (r_vcnt == '0);
      r_line_start  <= (r_hcnt == '0);
    end
  end

  assign cfg_pending = r_pending;
  assign cfg_applied = r_applied;
  assign cfg_error   = r_error;
  assign video_de    = r_de;
  assign video_hsync = r_hsync;
  assign video_vsync = r_vsync;
  assign pixel_x     = r_px;
  assign pixel_y     = r_py;
  assign frame_start = r_frame_start;
  assign line_start  = r_line_start;

  // Upper data bits and offset carry bits are intentionally unused.
  logic w_unused;
  assign w_unused = ^{cfg_data, w_h_off[c_HW-1:H_BITS], w_v_off[c_VW-1:V_BITS]};

endmodule
`default_nettype wire

// File: tb/tb_video_timing_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_timing_controller
// Purpose  : Self-checking bench for video_timing_controller. A reference
//            model tracks the linear pixel position inside the frame and
//            derives every expected output from the timing field values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_video_timing_controller;

  localparam int H_BITS = 12;
  localparam int V_BITS = 11;
  // Small defaults keep the default frame short (17 x 11 = 187 cycles).
  localparam int D_HS = 3, D_HB = 4, D_HA = 8, D_HF = 2;
  localparam int D_VS = 2, D_VB = 2, D_VA = 6, D_VF = 1;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [3:0]        cfg_addr = '0;
  logic [15:0]       cfg_data = '0;
  logic              cfg_pending, cfg_applied, cfg_error;
  logic              video_de, video_hsync, video_vsync;
  logic [H_BITS-1:0] pixel_x;
  logic [V_BITS-1:0] pixel_y;
  logic              frame_start, line_start;

  always #5 clock = ~clock;

  video_timing_controller #(
    .H_BITS(H_BITS), .V_BITS(V_BITS),
    .DEF_HSYNC(D_HS), .DEF_HBACK(D_HB), .DEF_HACTIVE(D_HA), .DEF_HFRONT(D_HF),
    .DEF_VSYNC(D_VS), .DEF_VBACK(D_VB), .DEF_VACTIVE(D_VA), .DEF_VFRONT(D_VF)
  ) dut (
    .clock(clock), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_pending(cfg_pending), .cfg_applied(cfg_applied), .cfg_error(cfg_error),
    .video_de(video_de), .video_hsync(video_hsync), .video_vsync(video_vsync),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .frame_start(frame_start), .line_start(line_start)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: field sets indexed 0..3 = H sync/back/active/front,
  // 4..7 = V sync/back/active/front; position is v*HTOTAL + h.
  int m_act [8];
  int m_sh  [8];
  int m_pos;
  bit m_pend;

  bit e_de, e_hs, e_vs, e_fs, e_ls, e_app, e_err;
  int e_px, e_py;

  function automatic int m_ht();
    return m_act[0] + m_act[1] + m_act[2] + m_act[3];
  endfunction

  function automatic int m_vt();
    return m_act[4] + m_act[5] + m_act[6] + m_act[7];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_act  = '{D_HS, D_HB, D_HA, D_HF, D_VS, D_VB, D_VA, D_VF};
    m_sh   = m_act;
    m_pos  = 0;
    m_pend = 1'b0;
  endtask

  // One clock: drive inputs, advance the model across the edge, compare.
  task automatic step(input logic v, input logic [3:0] a, input logic [15:0] d, input logic r);
    int ht, vt, h, vv, hs0, vs0, last, val, st_h, st_v;
    bit fire, np;
    cfg_valid = v;
    cfg_addr  = a;
    cfg_data  = d;
    reset     = r;
    @(posedge clock);
    if (r) begin
      model_reset();
      {e_de, e_hs, e_vs, e_fs, e_ls, e_app, e_err} = '0;
      e_px = 0;
      e_py = 0;
    end else begin
      ht  = m_ht();
      vt  = m_vt();
      h   = m_pos % ht;
      vv  = m_pos / ht;
      hs0 = m_act[0] + m_act[1];
      vs0 = m_act[4] + m_act[5];
      e_hs = (h < m_act[0]);
      e_vs = (vv < m_act[4]);
      e_de = (h >= hs0) && (h < hs0 + m_act[2]) && (vv >= vs0) && (vv < vs0 + m_act[6]);
      e_px = e_de ? h - hs0 : 0;
      e_py = e_de ? vv - vs0 : 0;
      e_fs = (m_pos == 0);
      e_ls = (h == 0);
      last  = ht * vt - 1;
      fire  = v && !m_pend;
      np    = m_pend;
      e_app = 1'b0;
      e_err = 1'b0;
      if (m_pend && m_pos == last) begin
        m_act = m_sh;
        np    = 1'b0;
        e_app = 1'b1;
      end
      m_pos = (m_pos == last) ? 0 : m_pos + 1;
      if (fire) begin
        if (a < 4) begin
          val = int'(d) % (1 << H_BITS);
          m_sh[a] = (val == 0) ? 1 : val;
        end else if (a < 8) begin
          val = int'(d) % (1 << V_BITS);
          m_sh[a] = (val == 0) ? 1 : val;
        end else if (a == 8) begin
          st_h = m_sh[0] + m_sh[1] + m_sh[2] + m_sh[3];
          st_v = m_sh[4] + m_sh[5] + m_sh[6] + m_sh[7];
          if (st_h > (1 << H_BITS) || st_v > (1 << V_BITS)) e_err = 1'b1;
          else np = 1'b1;
        end
      end
      m_pend = np;
    end
    #1;
    chk("cfg_ready",   32'(cfg_ready),   32'(!m_pend));
    chk("cfg_pending", 32'(cfg_pending), 32'(m_pend));
    chk("cfg_applied", 32'(cfg_applied), 32'(e_app));
    chk("cfg_error",   32'(cfg_error),   32'(e_err));
    chk("video_de",    32'(video_de),    32'(e_de));
    chk("video_hsync", 32'(video_hsync), 32'(e_hs));
    chk("video_vsync", 32'(video_vsync), 32'(e_vs));
    chk("pixel_x",     32'(pixel_x),     32'(e_px));
    chk("pixel_y",     32'(pixel_y),     32'(e_py));
    chk("frame_start", 32'(frame_start), 32'(e_fs));
    chk("line_start",  32'(line_start),  32'(e_ls));
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 4'd0, 16'd0, 1'b0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    step(1'b1, a, d, 1'b0);
  endtask

  task automatic wr_mode(input int hs, hb, ha, hf, vs, vb, va, vf);
    wr(4'd0, 16'(hs)); wr(4'd1, 16'(hb)); wr(4'd2, 16'(ha)); wr(4'd3, 16'(hf));
    wr(4'd4, 16'(vs)); wr(4'd5, 16'(vb)); wr(4'd6, 16'(va)); wr(4'd7, 16'(vf));
  endtask

  // Waits (bounded) for the DUT applied pulse; exact timing is checked by step.
  task automatic wait_apply(input int limit);
    bit got;
    got = 1'b0;
    for (int i = 0; i < limit; i++) begin
      idle(1);
      if (cfg_applied === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk("apply_seen", 32'(got), 32'd1);
  endtask

  initial begin
    int n_de, n_hs, max_px, max_py, n, len;

    // Reset state
    repeat (3) step(1'b0, 4'd0, 16'd0, 1'b1);
    chk("reset_ready", 32'(cfg_ready), 32'd1);
    idle(20);

    // Small mode committed mid-frame; writes stall while pending
    wr_mode(2, 2, 4, 2, 1, 1, 3, 1);
    wr(4'd8, 16'd0);
    chk("commit_pending", 32'(cfg_pending), 32'd1);
    chk("commit_ready_low", 32'(cfg_ready), 32'd0);
    repeat (4) wr(4'd0, 16'd7);
    wait_apply(400);
    n_de = 0; n_hs = 0; max_px = 0; max_py = 0;
    for (int i = 0; i < 60; i++) begin
      idle(1);
      n_de += int'(video_de);
      n_hs += int'(video_hsync);
      if (video_de && int'(pixel_x) > max_px) max_px = int'(pixel_x);
      if (video_de && int'(pixel_y) > max_py) max_py = int'(pixel_y);
    end
    chk("small_de_count", 32'(n_de), 32'd12);
    chk("small_hsync_count", 32'(n_hs), 32'd12);
    chk("small_max_x", 32'(max_px), 32'd3);
    chk("small_max_y", 32'(max_py), 32'd2);

    // Randomized modes, including ignored addresses and masked upper data bits
    for (int it = 0; it < 3; it++) begin
      for (int a = 0; a < 8; a++)
        wr(4'(a), {4'($urandom), 12'($urandom_range(0, 4))});
      wr(4'($urandom_range(9, 15)), 16'($urandom));
      idle($urandom_range(0, 30));
      wr(4'd8, 16'd0);
      wait_apply(1000);
      idle($urandom_range(5, 40));
    end

    // Zero VFRONT is stored as 1: frame = 10 x (1+1+2+1) = 50
    wr_mode(2, 2, 4, 2, 1, 1, 2, 0);
    wr(4'd8, 16'd0);
    wait_apply(1000);
    idle(1);
    chk("fs_after_apply", 32'(frame_start), 32'd1);
    n = 0;
    for (int i = 0; i < 500; i++) begin
      idle(1);
      n++;
      if (frame_start === 1'b1) break;
    end
    chk("vfront0_frame_len", 32'(n), 32'd50);

    // Commit on the exact frame-end cycle applies one full frame later
    for (int i = 0; i < 200; i++) begin
      if (m_pos == m_ht() * m_vt() - 1) break;
      idle(1);
    end
    len = m_ht() * m_vt();
    wr(4'd8, 16'd0);
    chk("fe_commit_no_apply", 32'(cfg_applied), 32'd0);
    n = 0;
    for (int i = 0; i < 500; i++) begin
      idle(1);
      n++;
      if (cfg_applied === 1'b1) break;
    end
    chk("fe_commit_delay", 32'(n), 32'(len));

    // Horizontal total too large
    wr_mode(2, 100, 4095, 2, 1, 1, 3, 1);
    wr(4'd8, 16'd0);
    chk("h_err_pulse", 32'(cfg_error), 32'd1);
    chk("h_err_no_pend", 32'(cfg_pending), 32'd0);
    idle(1);
    chk("h_err_one_cycle", 32'(cfg_error), 32'd0);
    idle(20);

    // Vertical total too large
    wr_mode(2, 2, 4, 2, 1, 5, 2047, 1);
    wr(4'd8, 16'd0);
    chk("v_err_pulse", 32'(cfg_error), 32'd1);
    idle(10);

    // Exactly 2^H_BITS accepted; reset while pending discards it
    wr_mode(1, 1, 4093, 1, 1, 1, 3, 1);
    wr(4'd8, 16'd0);
    chk("limit_accept", 32'(cfg_pending), 32'd1);
    chk("limit_no_err", 32'(cfg_error), 32'd0);
    idle(10);
    step(1'b0, 4'd0, 16'd0, 1'b1);
    chk("rst_pending", 32'(cfg_pending), 32'd0);
    chk("rst_de", 32'(video_de), 32'd0);
    chk("rst_hsync", 32'(video_hsync), 32'd0);
    idle(1);
    chk("rst_frame_start", 32'(frame_start), 32'd1);
    idle(200);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
